// File: rtl/fetch_queue.sv
// Instruction fetch queue: compacts masked fetch packets into a circular buffer and presents the
// oldest DECODE_NUM entries to decode. Optional per-entry PC storage under `define FQ_PC_EN.
module fetch_queue #(
   parameter int unsigned DECODE_NUM = 4,
   parameter int unsigned FETCH_NUM  = 4,
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  flush,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [FETCH_NUM-1:0]                  in_mask,
   input  logic [FETCH_NUM-1:0][31:0]            in_instr,
`ifdef FQ_PC_EN
   input  logic [DATA_WIDTH-1:0]                 in_pc,
   output logic [DECODE_NUM-1:0][DATA_WIDTH-1:0] out_pc,
`endif
   output logic [DECODE_NUM-1:0][31:0]           out_instr,
   output logic [DECODE_NUM-1:0]                 out_valid,
   input  logic [$clog2(DECODE_NUM+1)-1:0]       deq_num,
   output logic [$clog2(DEPTH+1)-1:0]            count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned FW = $clog2(FETCH_NUM + 1);

   logic [31:0]              mem [DEPTH];
   logic [PW-1:0]            wr_ptr, rd_ptr;
   logic [FETCH_NUM-1:0][31:0] wdata;
   logic [FW-1:0]            mask_cnt, push_n;
   logic [CW-1:0]            avail, deq_ext, pop_n;
   logic                     push;
`ifdef FQ_PC_EN
   logic [DATA_WIDTH-1:0]    pc_mem [DEPTH];
   logic [FETCH_NUM-1:0][DATA_WIDTH-1:0] wpc;
`endif

   assign in_ready = (CW'(DEPTH) - count) >= CW'(FETCH_NUM);
   assign push     = in_valid & in_ready & ~flush;
   assign push_n   = push ? mask_cnt : '0;

   // Compaction: set slot s lands at position popcount(in_mask[s-1:0]).
   always_comb begin
      mask_cnt = '0;
      wdata    = '0;
`ifdef FQ_PC_EN
      wpc      = '0;
`endif
      for (int s = 0; s < FETCH_NUM; s++) begin
         if (in_mask[s]) begin
            for (int j = 0; j < FETCH_NUM; j++) begin
               if (mask_cnt == FW'(j)) begin
                  wdata[j] = in_instr[s];
`ifdef FQ_PC_EN
                  wpc[j]   = in_pc + DATA_WIDTH'(4 * s);
`endif
               end
            end
            mask_cnt = mask_cnt + FW'(1);
         end
      end
   end

   always_comb begin
      avail   = (count > CW'(DECODE_NUM)) ? CW'(DECODE_NUM) : count;
      deq_ext = CW'(deq_num);
      pop_n   = (deq_ext < avail) ? deq_ext : avail;
   end

   always_comb begin
      for (int i = 0; i < DECODE_NUM; i++) begin
         out_valid[i] = count > CW'(i);
         out_instr[i] = out_valid[i] ? mem[rd_ptr + PW'(i)] : '0;
`ifdef FQ_PC_EN
         out_pc[i]    = out_valid[i] ? pc_mem[rd_ptr + PW'(i)] : '0;
`endif
      end
   end

   // Storage is intentionally not reset; validity comes from count alone.
   always_ff @(posedge clk) begin
      for (int j = 0; j < FETCH_NUM; j++) begin
         if (FW'(j) < push_n) begin
            mem[wr_ptr + PW'(j)] <= wdata[j];
`ifdef FQ_PC_EN
            pc_mem[wr_ptr + PW'(j)] <= wpc[j];
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + PW'(push_n);
         rd_ptr <= rd_ptr + PW'(pop_n);
         count  <= count + CW'(push_n) - pop_n;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a reference queue is updated on every clock and the DUT
// window (valid, instr, count, ready, and PC when FQ_PC_EN is defined) is compared after each edge.
module tb_fetch_queue;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  flush;
   logic                  in_valid;
   logic                  in_ready;
   logic [3:0]            in_mask;
   logic [3:0][31:0]      in_instr;
   logic [63:0]           in_pc;
   logic [3:0][31:0]      out_instr;
   logic [3:0]            out_valid;
   logic [2:0]            deq_num;
   logic [4:0]            count;
`ifdef FQ_PC_EN
   logic [3:0][63:0]      out_pc;
`endif

   typedef struct {
      logic [31:0] instr;
      logic [63:0] pc;
   } entry_t;

   entry_t exp_q[$];
   int     n_cmp = 0;
   int     n_err = 0;
   int     seq   = 0;

   always #5 clk = ~clk;

   fetch_queue #(
      .DECODE_NUM(4),
      .FETCH_NUM (4),
      .DEPTH     (16),
      .DATA_WIDTH(64)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_mask  (in_mask),
      .in_instr (in_instr),
`ifdef FQ_PC_EN
      .in_pc    (in_pc),
      .out_pc   (out_pc),
`endif
      .out_instr(out_instr),
      .out_valid(out_valid),
      .deq_num  (deq_num),
      .count    (count)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic compare_all(input string tag);
      int          sz;
      logic [3:0]  ev;
      logic [31:0] ei;
      sz = exp_q.size();
      ev = '0;
      for (int i = 0; i < 4; i++) ev[i] = (sz > i);
      check({tag, ".count"}, 64'(count), 64'(sz));
      check({tag, ".in_ready"}, 64'(in_ready), 64'((16 - sz) >= 4));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
      for (int i = 0; i < 4; i++) begin
         ei = (sz > i) ? exp_q[i].instr : 32'h0;
         check($sformatf("%s.instr%0d", tag, i), 64'(out_instr[i]), 64'(ei));
`ifdef FQ_PC_EN
         check($sformatf("%s.pc%0d", tag, i), out_pc[i], (sz > i) ? exp_q[i].pc : 64'h0);
`endif
      end
   endtask

   // Drive one cycle, clock it, update the reference model, then compare.
   task automatic cycle(input string tag, input logic v, input logic [3:0] m,
                        input logic [3:0][31:0] ins, input logic [2:0] dq,
                        input logic fl, input logic [63:0] pc);
      int sz, avail, pn;
      bit rdy;
      in_valid = v;
      in_mask  = m;
      in_instr = ins;
      deq_num  = dq;
      flush    = fl;
      in_pc    = pc;
      @(posedge clk);
      sz    = exp_q.size();
      rdy   = (16 - sz) >= 4;
      avail = (sz < 4) ? sz : 4;
      pn    = (int'(dq) < avail) ? int'(dq) : avail;
      if (fl) begin
         exp_q.delete();
      end else begin
         repeat (pn) void'(exp_q.pop_front());
         if (v && rdy)
            for (int s = 0; s < 4; s++)
               if (m[s]) exp_q.push_back('{instr: ins[s], pc: pc + 64'(4 * s)});
      end
      #1;
      compare_all(tag);
   endtask

   function automatic logic [3:0][31:0] pkt();
      logic [3:0][31:0] p;
      for (int s = 0; s < 4; s++) begin
         p[s] = 32'hC000_0000 + 32'(seq);
         seq++;
      end
      return p;
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0][31:0] abcd;
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_mask = '0;
      in_instr = '0; deq_num = '0; in_pc = '0;
      #1;
      compare_all("reset");
      #11 rst_n = 1'b1;

      // Single full packet, then full dequeue.
      abcd = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      cycle("full_pkt", 1, 4'b1111, abcd, 0, 0, 64'h2000);
      cycle("deq4", 0, 4'b0000, '0, 4, 0, 0);

      // Sparse packet: slots 1 and 3 only.
      cycle("sparse", 1, 4'b1010, abcd, 0, 0, 64'h1000);
      check("sparse.instr0_is_B", 64'(out_instr[0]), 64'h0000_0000_BBBB_0001);
`ifdef FQ_PC_EN
      check("sparse.pc1", out_pc[1], 64'h100C);
`endif
      cycle("drain", 0, 4'b0000, '0, 4, 0, 0);

      // Fill to 16, then hold a packet while not ready.
      for (int k = 0; k < 4; k++) cycle("fill", 1, 4'b1111, pkt(), 0, 0, 64'(k * 16));
      check("full.in_ready", 64'(in_ready), 64'h0);
      cycle("hold", 1, 4'b1111, pkt(), 0, 0, 0);
      cycle("hold2", 1, 4'b1111, pkt(), 0, 0, 0);
      for (int k = 0; k < 4; k++) cycle("empty_out", 0, 4'b0000, '0, 4, 0, 0);

      // Wrap: continuous push 4 / pop 4.
      cycle("wrap0", 1, 4'b1111, pkt(), 0, 0, 64'h3000);
      for (int k = 0; k < 10; k++) cycle("wrap", 1, 4'b1111, pkt(), 4, 0, 64'(k * 4));
      cycle("wrap_drain", 0, 4'b0000, '0, 4, 0, 0);

      // Over-dequeue with two entries, then a new packet shows in slot 0.
      cycle("two", 1, 4'b0011, pkt(), 0, 0, 64'h40);
      cycle("overdeq", 0, 4'b0000, '0, 4, 0, 0);
      cycle("after_over", 1, 4'b0100, pkt(), 0, 0, 64'h80);
      cycle("drain2", 0, 4'b0000, '0, 4, 0, 0);

      // Flush with count 8 while pushing and popping.
      cycle("f1", 1, 4'b1111, pkt(), 0, 0, 0);
      cycle("f2", 1, 4'b1111, pkt(), 0, 0, 0);
      cycle("flush", 1, 4'b1111, pkt(), 2, 1, 0);

      // Randomised traffic.
      for (int k = 0; k < 300; k++)
         cycle("rand", 1'($urandom_range(0, 3) != 0), 4'($urandom), pkt(),
               3'($urandom_range(0, 4)), 1'($urandom_range(0, 40) == 0), 64'($urandom) << 2);

      // Asynchronous reset mid-stream, checked before any clock edge.
      cycle("pre_rst", 1, 4'b1111, pkt(), 0, 0, 0);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      compare_all("async_rst");
      #2 rst_n = 1'b1;
      cycle("post_rst", 1, 4'b0001, pkt(), 0, 0, 64'h500);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
